// File: rtl/mm_pkg.sv
// Shared types for the main-memory responder: op codes, FSM states,
// completion status codes.
package mm_pkg;

  typedef enum logic [1:0] {
    OP_RD    = 2'b00,
    OP_WR    = 2'b01,
    OP_RDBLK = 2'b10,
    OP_RSV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_e;

  localparam logic ESITO_OK  = 1'b0;
  localparam logic ESITO_ERR = 1'b1;

endpackage

// File: rtl/mm_array.sv
// Single-port synchronous word array with registered read port.
// Contents are never cleared; only the read register is reset.
module mm_array
  import mm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/mm_responder.sv
// Memory-side end of the MMU rdy/ack link: word read/write, block read.
// Define MM_BOUNDS_CHECK_EN to fail out-of-range accesses instead of wrapping.
module mm_responder
  import mm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 256,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rdyin,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] ind,
  input  logic [DATA_W-1:0] datain,
  output logic              ackout,
  output logic              esito,
  output logic [DATA_W-1:0] dataout,
  output logic              dout_valid
);

  localparam int MA_W = $clog2(MEM_WORDS);
  localparam int BW_W = $clog2(BLOCK_WORDS);
  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(BLOCK_WORDS-1);
  localparam logic [BW_W-1:0] LAST = BW_W'(BLOCK_WORDS-1);

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] ind_q;
  logic [DATA_W-1:0] din_q;
  logic [CW-1:0]     cnt;
  logic [BW_W-1:0]   off;
  logic              rdy_seen;

  logic              fire;
  logic              oob;
  logic              arr_re;
  logic              arr_we;
  logic [MA_W-1:0]   arr_addr;
  logic [ADDR_W:0]   last_x;

  assign fire = (state == S_WAIT) && (cnt == '0);

  always_comb begin
    last_x = {1'b0, ind};
    oob    = 1'b0;
`ifdef MM_BOUNDS_CHECK_EN
    // aligned block: OR-ing the span gives its last word address
    if (op == OP_RDBLK) last_x = {1'b0, ind} | SPAN;
    oob = (last_x >= LIM);
`endif
  end

  always_comb begin
    arr_we   = fire && (op_q == OP_WR);
    arr_re   = (fire && (op_q != OP_WR)) || (state == S_XFER);
    arr_addr = ind_q[MA_W-1:0];
    if (state == S_XFER)
      arr_addr = {ind_q[MA_W-1:BW_W], off};
    else if (op_q == OP_RDBLK)
      arr_addr = {ind_q[MA_W-1:BW_W], {BW_W{1'b0}}};
  end

  mm_array #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS),
    .AW        (MA_W)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .re      (arr_re),
    .we      (arr_we),
    .addr    (arr_addr),
    .wdata   (din_q),
    .rdata   (dataout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= OP_RD;
      ind_q      <= '0;
      din_q      <= '0;
      cnt        <= '0;
      off        <= '0;
      rdy_seen   <= 1'b0;
      ackout     <= 1'b0;
      esito      <= ESITO_OK;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= arr_re;
      unique case (state)
        S_IDLE: begin
          if (rdyin != rdy_seen) begin
            rdy_seen <= rdyin;
            op_q     <= op_e'(op);
            ind_q    <= ind;
            din_q    <= datain;
            cnt      <= CW'(LATENCY-1);
            state    <= (op == OP_RSV || oob) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (op_q == OP_RDBLK) begin
            off   <= BW_W'(1);
            state <= S_XFER;
          end else begin
            esito  <= ESITO_OK;
            ackout <= ~ackout;
            state  <= S_IDLE;
          end
        end
        S_XFER: begin
          if (off == LAST) begin
            esito  <= ESITO_OK;
            ackout <= ~ackout;
            state  <= S_IDLE;
          end else begin
            off <= off + 1'b1;
          end
        end
        S_DONE: begin
          esito  <= ESITO_ERR;
          ackout <= ~ackout;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
